// File: rtl/fmdll_lock_ctrl.sv
// fmdll_lock_ctrl: lock controller for the frequency-multiplying DLL.
// It runs on CLK_exit and owns the M/N edge counters.
// It sets the DCDL delay code with a binary search, then tracks it in +/-1 steps.
// While tracking it detects lock and loss of lock.
// A settle window gates phase samples after every code change.
module fmdll_lock_ctrl #(
    parameter int CODE_W    = 6,
    parameter int M_W       = 2,
    parameter int N_W       = 3,
    parameter int SETTLE    = 4,
    parameter int LOCK_CNT  = 8,
    parameter int UNLOCK_TH = 3
) (
    input  logic              CLK_exit,
    input  logic              rst,
    input  logic              en,
    input  logic [1:0]        Sel,
    input  logic [M_W-1:0]    M,
    input  logic [N_W-1:0]    N,
    input  logic              pd_valid,
    input  logic              pd_late,
    output logic [CODE_W-1:0] code,
    output logic [1:0]        clk_sel,
    output logic [M_W-1:0]    m_cnt,
    output logic [N_W-1:0]    n_cnt,
    output logic              lock,
    output logic              busy,
    output logic              err
);

    localparam int SET_W = $clog2(SETTLE + 1);
    localparam int REV_W = $clog2(LOCK_CNT + 1);
    localparam int RUN_W = $clog2(UNLOCK_TH + 1);
    localparam int PTR_W = (CODE_W > 1) ? $clog2(CODE_W) : 1;

    localparam logic [CODE_W-1:0] CODE_ZERO = {CODE_W{1'b0}};
    localparam logic [CODE_W-1:0] CODE_ONE  = {{(CODE_W-1){1'b0}}, 1'b1};
    localparam logic [CODE_W-1:0] CODE_MAX  = {CODE_W{1'b1}};
    localparam logic [CODE_W-1:0] CODE_MID  = {1'b1, {(CODE_W-1){1'b0}}};
    localparam logic [SET_W-1:0]  SET_ZERO  = {SET_W{1'b0}};
    localparam logic [SET_W-1:0]  SET_ONE   = {{(SET_W-1){1'b0}}, 1'b1};
    localparam logic [SET_W-1:0]  SETTLE_V  = SET_W'(SETTLE);
    localparam logic [REV_W-1:0]  REV_ZERO  = {REV_W{1'b0}};
    localparam logic [REV_W-1:0]  REV_ONE   = {{(REV_W-1){1'b0}}, 1'b1};
    localparam logic [REV_W-1:0]  LOCK_V    = REV_W'(LOCK_CNT);
    localparam logic [RUN_W-1:0]  RUN_ZERO  = {RUN_W{1'b0}};
    localparam logic [RUN_W-1:0]  RUN_ONE   = {{(RUN_W-1){1'b0}}, 1'b1};
    localparam logic [RUN_W-1:0]  UNLOCK_V  = RUN_W'(UNLOCK_TH);
    localparam logic [PTR_W-1:0]  PTR_ZERO  = {PTR_W{1'b0}};
    localparam logic [PTR_W-1:0]  PTR_ONE   = {{(PTR_W-1){1'b0}}, 1'b1};
    localparam logic [PTR_W-1:0]  PTR_TOP   = PTR_W'(CODE_W - 1);
    localparam logic [M_W-1:0]    M_ZERO    = {M_W{1'b0}};
    localparam logic [M_W-1:0]    M_ONE     = {{(M_W-1){1'b0}}, 1'b1};
    localparam logic [N_W-1:0]    N_ZERO    = {N_W{1'b0}};
    localparam logic [N_W-1:0]    N_ONE     = {{(N_W-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SEARCH = 3'd1,
        ST_TRACK  = 3'd2,
        ST_LOCKED = 3'd3,
        ST_BYPASS = 3'd4
    } state_t;

    state_t              state_r, state_nxt_s;
    logic [CODE_W-1:0]   code_r, code_nxt_s;
    logic [PTR_W-1:0]    ptr_r, ptr_nxt_s;
    logic [REV_W-1:0]    rev_cnt_r, rev_nxt_s, rev_step_s;
    logic [RUN_W-1:0]    run_cnt_r, run_nxt_s, run_step_s;
    logic                last_dir_r, dir_nxt_s;
    logic                dir_vld_r, dir_vld_nxt_s;
    logic [SET_W-1:0]    settle_r, settle_nxt_s;
    logic                err_r, err_nxt_s;
    logic                lock_r, busy_r;
    logic [1:0]          clk_sel_r;
    logic [M_W-1:0]      m_cnt_r, m_nxt_s, m_prev_r, m_eff_s;
    logic [N_W-1:0]      n_cnt_r, n_nxt_s, n_prev_r, n_eff_s;

    logic [1:0]          sel_map_s;
    logic                sel_chg_s;
    logic                accept_s;
    logic                sat_s;
    logic                code_load_s;
    logic [CODE_W-1:0]   mask_s;
    logic [CODE_W-1:0]   search_code_s;
    logic [CODE_W-1:0]   step_code_s;
    logic                step_sat_s;
    logic                reversal_s;

    // Mode decode: 11 behaves as multiply; any difference to the registered select is a mode change
    assign sel_map_s  = (Sel == 2'b11) ? 2'b00 : Sel;
    assign sel_chg_s  = (sel_map_s != clk_sel_r);
    assign accept_s   = pd_valid && (settle_r == SET_ZERO);

    // SAR update: the pointed bit follows the comparator, the next lower bit becomes the new trial bit
    assign mask_s        = CODE_ONE << ptr_r;
    assign search_code_s = (code_r & ~mask_s) | (pd_late ? CODE_ZERO : mask_s) | (mask_s >> 1);

    // Tracking step, end-of-range detection and reversal/run bookkeeping
    assign step_sat_s  = pd_late ? (code_r == CODE_ZERO) : (code_r == CODE_MAX);
    assign step_code_s = pd_late ? (code_r - CODE_ONE) : (code_r + CODE_ONE);
    assign reversal_s  = dir_vld_r && (pd_late != last_dir_r);
    assign rev_step_s  = reversal_s ? (rev_cnt_r + REV_ONE) : REV_ZERO;
    assign run_step_s  = (!dir_vld_r || reversal_s) ? RUN_ONE :
                         ((run_cnt_r == UNLOCK_V) ? run_cnt_r : (run_cnt_r + RUN_ONE));

    // Controller next state: enable and mode changes override, then per-state search/track rules
    always_comb begin
        state_nxt_s   = state_r;
        code_nxt_s    = code_r;
        ptr_nxt_s     = ptr_r;
        rev_nxt_s     = rev_cnt_r;
        run_nxt_s     = run_cnt_r;
        dir_nxt_s     = last_dir_r;
        dir_vld_nxt_s = dir_vld_r;
        sat_s         = 1'b0;
        code_load_s   = 1'b0;
        if (!en) begin
            state_nxt_s = ST_IDLE;
        end else if (sel_chg_s && (state_r != ST_IDLE)) begin
            state_nxt_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (sel_map_s == 2'b00) begin
                        state_nxt_s = ST_SEARCH;
                        code_nxt_s  = CODE_MID;
                        ptr_nxt_s   = PTR_TOP;
                        code_load_s = 1'b1;
                    end else if (sel_map_s == 2'b01) begin
                        state_nxt_s = ST_BYPASS;
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end
                ST_SEARCH: begin
                    if (accept_s) begin
                        code_nxt_s = search_code_s;
                        if (ptr_r != PTR_ZERO) begin
                            ptr_nxt_s = ptr_r - PTR_ONE;
                        end else begin
                            state_nxt_s   = ST_TRACK;
                            rev_nxt_s     = REV_ZERO;
                            run_nxt_s     = RUN_ZERO;
                            dir_vld_nxt_s = 1'b0;
                        end
                    end else begin
                        state_nxt_s = ST_SEARCH;
                    end
                end
                ST_TRACK, ST_LOCKED: begin
                    if (accept_s && step_sat_s) begin
                        sat_s       = 1'b1;
                        state_nxt_s = ST_SEARCH;
                        code_nxt_s  = CODE_MID;
                        ptr_nxt_s   = PTR_TOP;
                        code_load_s = 1'b1;
                    end else if (accept_s) begin
                        code_nxt_s    = step_code_s;
                        dir_nxt_s     = pd_late;
                        dir_vld_nxt_s = 1'b1;
                        run_nxt_s     = run_step_s;
                        if (state_r == ST_TRACK) begin
                            rev_nxt_s = rev_step_s;
                            if (rev_step_s == LOCK_V) begin
                                state_nxt_s = ST_LOCKED;
                            end else begin
                                state_nxt_s = ST_TRACK;
                            end
                        end else if (run_step_s == UNLOCK_V) begin
                            state_nxt_s = ST_TRACK;
                            rev_nxt_s   = REV_ZERO;
                        end else begin
                            state_nxt_s = ST_LOCKED;
                        end
                    end else begin
                        state_nxt_s = state_r;
                    end
                end
                ST_BYPASS: begin
                    state_nxt_s = ST_BYPASS;
                end
                default: begin
                    state_nxt_s = ST_IDLE;
                end
            endcase
        end
    end

    // Settle window reloads on every code load/change and otherwise counts down to zero
    always_comb begin
        settle_nxt_s = settle_r;
        if (code_load_s || (code_nxt_s != code_r)) begin
            settle_nxt_s = SETTLE_V;
        end else if (settle_r != SET_ZERO) begin
            settle_nxt_s = settle_r - SET_ONE;
        end else begin
            settle_nxt_s = SET_ZERO;
        end
    end

    // Sticky saturation error, cleared by a mode change
    always_comb begin
        err_nxt_s = err_r;
        if (sel_chg_s) begin
            err_nxt_s = 1'b0;
        end else if (sat_s) begin
            err_nxt_s = 1'b1;
        end else begin
            err_nxt_s = err_r;
        end
    end

    // Edge counters: ratio 0 acts as 1, held at zero when off or when a ratio changes
    always_comb begin
        m_eff_s = (M == M_ZERO) ? M_ONE : M;
        n_eff_s = (N == N_ZERO) ? N_ONE : N;
        m_nxt_s = m_cnt_r;
        n_nxt_s = n_cnt_r;
        if ((sel_map_s == 2'b10) || (M != m_prev_r) || (N != n_prev_r)) begin
            m_nxt_s = M_ZERO;
            n_nxt_s = N_ZERO;
        end else if (m_cnt_r == (m_eff_s - M_ONE)) begin
            m_nxt_s = M_ZERO;
            if (n_cnt_r == (n_eff_s - N_ONE)) begin
                n_nxt_s = N_ZERO;
            end else begin
                n_nxt_s = n_cnt_r + N_ONE;
            end
        end else begin
            m_nxt_s = m_cnt_r + M_ONE;
            n_nxt_s = n_cnt_r;
        end
    end

    // Controller registers; lock and busy are registered decodes of the next state
    always_ff @(posedge CLK_exit) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            code_r     <= CODE_MID;
            ptr_r      <= PTR_TOP;
            rev_cnt_r  <= REV_ZERO;
            run_cnt_r  <= RUN_ZERO;
            last_dir_r <= 1'b0;
            dir_vld_r  <= 1'b0;
            settle_r   <= SETTLE_V;
            err_r      <= 1'b0;
            lock_r     <= 1'b0;
            busy_r     <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            code_r     <= code_nxt_s;
            ptr_r      <= ptr_nxt_s;
            rev_cnt_r  <= rev_nxt_s;
            run_cnt_r  <= run_nxt_s;
            last_dir_r <= dir_nxt_s;
            dir_vld_r  <= dir_vld_nxt_s;
            settle_r   <= settle_nxt_s;
            err_r      <= err_nxt_s;
            lock_r     <= (state_nxt_s == ST_LOCKED);
            busy_r     <= (state_nxt_s == ST_SEARCH) || (state_nxt_s == ST_TRACK) ||
                          (state_nxt_s == ST_LOCKED);
        end
    end

    // Clock select and counter registers, with the ratios kept to detect changes
    always_ff @(posedge CLK_exit) begin
        if (rst) begin
            clk_sel_r <= 2'b10;
            m_cnt_r   <= M_ZERO;
            n_cnt_r   <= N_ZERO;
            m_prev_r  <= M;
            n_prev_r  <= N;
        end else begin
            clk_sel_r <= sel_map_s;
            m_cnt_r   <= m_nxt_s;
            n_cnt_r   <= n_nxt_s;
            m_prev_r  <= M;
            n_prev_r  <= N;
        end
    end

    assign code    = code_r;
    assign clk_sel = clk_sel_r;
    assign m_cnt   = m_cnt_r;
    assign n_cnt   = n_cnt_r;
    assign lock    = lock_r;
    assign busy    = busy_r;
    assign err     = err_r;

endmodule
